// File: rtl/keccak_pkg.sv
// Shared Keccak constants, lane indexing and the chi sequencer FSM encoding.
package keccak_pkg;

  localparam int NUM_LANES       = 25;
  localparam int NUM_PLANES      = 5;
  localparam int LANES_PER_PLANE = NUM_LANES / NUM_PLANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } chi_state_e;

  function automatic int idx(input int x, input int y);
    return x + 5 * y;
  endfunction

endpackage

// File: rtl/keccak_chi_plane.sv
// Combinational chi over one plane of five lanes.
module keccak_chi_plane
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [LANES_PER_PLANE*LANE_W-1:0] plane_i,
  output logic [LANES_PER_PLANE*LANE_W-1:0] plane_o
);

  // out[x] = a[x] ^ (~a[x+1] & a[x+2]), indices mod 5
  always_comb begin
    plane_o = '0;
    for (int x = 0; x < LANES_PER_PLANE; x++) begin
      plane_o[x*LANE_W +: LANE_W] =
          plane_i[x*LANE_W +: LANE_W] ^
          (~plane_i[((x + 1) % LANES_PER_PLANE)*LANE_W +: LANE_W] &
            plane_i[((x + 2) % LANES_PER_PLANE)*LANE_W +: LANE_W]);
    end
  end

endmodule

// File: rtl/keccak_chi_seq.sv
// Sequential Keccak chi step, PPC planes per cycle, with valid/ready on both sides.
// Define KECCAK_CHI_IOTA_EN to fuse iota (lane 0 ^= in_rc) into the plane-0 pass.
module keccak_chi_seq
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int PPC    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES*LANE_W-1:0] in_state,
  input  logic [LANE_W-1:0]           in_rc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES*LANE_W-1:0] out_state
);

  localparam int STATE_W = NUM_LANES * LANE_W;
  localparam int PLANE_W = LANES_PER_PLANE * LANE_W;
  localparam logic [2:0] CNT_STEP = 3'(PPC);
  localparam logic [2:0] LAST_CNT = 3'(NUM_PLANES - PPC);

  chi_state_e          fsm_q, fsm_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [LANE_W-1:0]   rc_q, rc_d;
  logic [LANE_W-1:0]   iota_s;
  logic                in_fire_s;
  logic                last_s;

  logic [PPC-1:0][PLANE_W-1:0] plane_in_s;
  logic [PPC-1:0][PLANE_W-1:0] plane_out_s;

  for (genvar g = 0; g < PPC; g++) begin : g_plane
    keccak_chi_plane #(.LANE_W(LANE_W)) u_plane (
      .plane_i (plane_in_s[g]),
      .plane_o (plane_out_s[g])
    );
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) fsm_d = BUSY;
        else          fsm_d = IDLE;
      end
      BUSY: begin
        if (last_s) fsm_d = DONE;
        else        fsm_d = BUSY;
      end
      DONE: begin
        if (out_ready) fsm_d = in_valid ? BUSY : IDLE;
        else           fsm_d = DONE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // FSM outputs and handshake qualifiers
  always_comb begin
    in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
    out_valid = (fsm_q == DONE);
    in_fire_s = in_valid & in_ready;
    last_s    = (cnt_q == LAST_CNT);
  end

  // Gather the PPC planes addressed by the counter
  always_comb begin
    plane_in_s = '0;
    for (int g = 0; g < PPC; g++) begin
      for (int x = 0; x < LANES_PER_PLANE; x++) begin
        plane_in_s[g][x*LANE_W +: LANE_W] =
            state_q[idx(x, int'(cnt_q) + g)*LANE_W +: LANE_W];
      end
    end
  end

`ifdef KECCAK_CHI_IOTA_EN
  // Round constant lands on lane 0 only during the pass that rewrites plane 0
  always_comb begin
    if ((fsm_q == BUSY) && (cnt_q == 3'd0)) iota_s = rc_q;
    else                                    iota_s = '0;
  end
`else
  logic unused_rc_s;
  // Round constant is captured but takes no part in the result
  always_comb begin
    iota_s      = '0;
    unused_rc_s = ^rc_q;
  end
`endif

  // Datapath next state: capture, in-place plane update, counter
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    if (in_fire_s) begin
      state_d = in_state;
      rc_d    = in_rc;
      cnt_d   = 3'd0;
    end else if (fsm_q == BUSY) begin
      for (int g = 0; g < PPC; g++) begin
        for (int x = 0; x < LANES_PER_PLANE; x++) begin
          state_d[idx(x, int'(cnt_q) + g)*LANE_W +: LANE_W] =
              plane_out_s[g][x*LANE_W +: LANE_W];
        end
      end
      state_d[LANE_W-1:0] = state_d[LANE_W-1:0] ^ iota_s;
      if (last_s) cnt_d = cnt_q;
      else        cnt_d = cnt_q + CNT_STEP;
    end else begin
      state_d = state_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rc_q    <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_state = state_q;

endmodule

// File: tb/tb_keccak_chi_seq.sv
// Self-checking bench: a 64-bit/PPC=1 instance and an 8-bit/PPC=5 instance against a lane-array chi model.
module tb_keccak_chi_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic          a_in_valid = 1'b0;
  logic          a_in_ready;
  logic [1599:0] a_in_state = '0;
  logic [63:0]   a_in_rc = '0;
  logic          a_out_valid;
  logic          a_out_ready = 1'b1;
  logic [1599:0] a_out_state;

  logic          b_in_valid = 1'b0;
  logic          b_in_ready;
  logic [199:0]  b_in_state = '0;
  logic [7:0]    b_in_rc = '0;
  logic          b_out_valid;
  logic          b_out_ready = 1'b1;
  logic [199:0]  b_out_state;

  keccak_chi_seq #(.LANE_W(64), .PPC(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_state(a_in_state), .in_rc(a_in_rc),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_state(a_out_state)
  );

  keccak_chi_seq #(.LANE_W(8), .PPC(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_state(b_in_state), .in_rc(b_in_rc),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_state(b_out_state)
  );

  // Reference: unpack into a 5x5 lane array, apply chi (and iota) row by row, repack.
  function automatic logic [1599:0] ref_chi(input logic [1599:0] s, input logic [63:0] rc, input int w);
    logic [63:0]   a [25];
    logic [63:0]   r;
    logic [63:0]   m;
    logic [1599:0] o;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    o = '0;
    for (int i = 0; i < 25; i++) begin
      a[i] = 64'd0;
      for (int b = 0; b < w; b++) a[i][b] = s[i*w + b];
    end
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r = a[x + 5*y] ^ (~a[(x+1)%5 + 5*y] & a[(x+2)%5 + 5*y]);
`ifdef KECCAK_CHI_IOTA_EN
        if (x == 0 && y == 0) r = r ^ rc;
`endif
        r = r & m;
        for (int b = 0; b < w; b++) o[(x + 5*y)*w + b] = r[b];
      end
    end
    return o;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  // Offer a state to instance A from the drive phase; returns just after the accepting edge.
  task automatic a_send(input logic [1599:0] s, input logic [63:0] rc);
    bit fire;
    bit done;
    done = 1'b0;
    a_in_valid = 1'b1;
    a_in_state = s;
    a_in_rc    = rc;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      fire = a_in_ready;
      @(posedge clk);
      #1;
      if (fire) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL a_send_accept: in_ready got 0 expected 1 within 50 cycles");
    end
    a_in_valid = 1'b0;
    a_in_state = rand_state();
    a_in_rc    = {$urandom, $urandom};
  endtask

  // Count edges until out_valid is seen; ends on a negedge with out_valid high.
  task automatic a_wait_out(output int edges);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < 50) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL a_wait_out: out_valid got 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got a=%b b=%b expected 0", a_out_valid, b_out_valid);
    end
    checks++;
    if (a_out_state !== 1600'd0 || b_out_state !== 200'd0) begin
      errors++;
      $display("FAIL reset_out_state: got nonzero expected 0");
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got a=%b b=%b expected 1", a_in_ready, b_in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero();
    int lat;
    a_send('0, 64'd0);
    a_wait_out(lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 5", lat);
    end
    checks++;
    if (a_out_state !== 1600'd0) begin
      errors++;
      $display("FAIL zero_state: got %h expected 0", a_out_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lane2();
    int lat;
    logic [1599:0] s;
    logic [1599:0] exp;
    logic [63:0]   lane0;
    s = '0;
    s[2*64 +: 64] = {64{1'b1}};
`ifdef KECCAK_CHI_IOTA_EN
    lane0 = 64'hFFFF_FFFF_FFFF_FFFE;
`else
    lane0 = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
    exp = '0;
    exp[0 +: 64] = lane0;
    exp[2*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    a_send(s, 64'h0000_0000_0000_0001);
    a_wait_out(lat);
    checks++;
    if (a_out_state !== exp) begin
      errors++;
      $display("FAIL lane2_state: got lane0=%h lane2=%h expected lane0=%h lane2=ffffffffffffffff", a_out_state[63:0], a_out_state[191:128], lane0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int lat;
    logic [1599:0] s;
    logic [63:0]   rc;
    logic [1599:0] exp;
    for (int k = 0; k < 6; k++) begin
      s   = rand_state();
      rc  = {$urandom, $urandom};
      exp = ref_chi(s, rc, 64);
      a_send(s, rc);
      a_wait_out(lat);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL random_latency[%0d]: got %0d expected 5", k, lat);
      end
      checks++;
      if (a_out_state !== exp) begin
        errors++;
        $display("FAIL random_state[%0d]: got lane0=%h expected lane0=%h", k, a_out_state[63:0], exp[63:0]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    int lat;
    int bad;
    logic [1599:0] s1, s2, exp1, exp2;
    logic [63:0] rc1, rc2;
    s1 = rand_state(); rc1 = {$urandom, $urandom}; exp1 = ref_chi(s1, rc1, 64);
    s2 = rand_state(); rc2 = {$urandom, $urandom}; exp2 = ref_chi(s2, rc2, 64);
    a_out_ready = 1'b0;
    a_send(s1, rc1);
    a_wait_out(lat);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_out_valid !== 1'b1 || a_out_state !== exp1 || a_in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
    end
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_state  = s2;
    a_in_rc     = rc2;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b expected 1", a_in_ready);
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_in_state = rand_state();
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_same_edge: out_valid got %b expected 0", a_out_valid);
    end
    @(posedge clk);
    #1;
    a_wait_out(lat);
    checks++;
    if (lat !== 4 || a_out_state !== exp2) begin
      errors++;
      $display("FAIL stall_second: got edges=%0d lane0=%h expected edges=4 lane0=%h", lat, a_out_state[63:0], exp2[63:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_busy();
    int lat;
    int bad;
    logic [1599:0] s, exp;
    logic [63:0] rc;
    a_send(rand_state(), {$urandom, $urandom});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_out_state !== 1600'd0) begin
      errors++;
      $display("FAIL busy_reset_clear: got valid=%b lane0=%h expected 0", a_out_valid, a_out_state[63:0]);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) bad++;
      @(posedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_reset_quiet: got %0d bad cycles expected 0", bad);
    end
    #1;
    s = rand_state(); rc = {$urandom, $urandom}; exp = ref_chi(s, rc, 64);
    a_send(s, rc);
    a_wait_out(lat);
    checks++;
    if (lat !== 5 || a_out_state !== exp) begin
      errors++;
      $display("FAIL busy_reset_next: got edges=%0d lane0=%h expected edges=5 lane0=%h", lat, a_out_state[63:0], exp[63:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [199:0] q [$];
    logic [199:0] exp;
    logic [1599:0] full;
    int sent, got, cyc, last_cyc, gap_bad;
    bit fire;
    sent = 0; got = 0; cyc = 0; last_cyc = -1; gap_bad = 0;
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    full = rand_state();
    b_in_state = full[199:0];
    b_in_rc    = 8'($urandom);
    while (got < 100 && cyc < 1000) begin
      @(negedge clk);
      fire = b_in_ready;
      if (b_out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : '0;
        checks++;
        if (b_out_state !== exp) begin
          errors++;
          $display("FAIL b2b_state[%0d]: got %h expected %h", got, b_out_state, exp);
        end
        if (last_cyc >= 0 && cyc - last_cyc != 2) gap_bad++;
        last_cyc = cyc;
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (fire && b_in_valid) begin
        full = ref_chi({1400'd0, b_in_state}, {56'd0, b_in_rc}, 8);
        q.push_back(full[199:0]);
        sent++;
        if (sent < 100) begin
          full = rand_state();
          b_in_state = full[199:0];
          b_in_rc    = 8'($urandom);
        end else begin
          b_in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (got != 100) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 100", got);
    end
    checks++;
    if (gap_bad != 0) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d gaps not equal 2 expected 0", gap_bad);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_lane2();
    test_random();
    test_stall();
    test_reset_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
